// File: rtl/change_payout.sv
// ============================================================================
// Module      : change_payout
// Description : Item release and one-coin-at-a-time change payout from a
//               two-tube hopper, with sense handshake, timeout and fault.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_payout #(
    parameter int PULSE_CYCLES   = 3,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int CW             = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vend,
    input  logic          change_1,
    input  logic          change_2,
    input  logic          coin_sensed,
    input  logic          clear_fault,
    output logic          coin_eject,
    output logic          coin_type,
    output logic          item_release,
    output logic          busy,
    output logic          fault,
    output logic          h2_empty,
    output logic          overflow,
    output logic [CW-1:0] credit
);

    localparam int TW = $clog2(((PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES) + 1);
    localparam int IW = $clog2(PULSE_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EJECT = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [CW-1:0] CMAX = '1;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [TW-1:0] timer;
    logic          sensed;
    logic          timeout;
    logic [1:0]    paid;
    logic [CW+1:0] credit_sum;
    logic [IW-1:0] item_cnt;
    logic          item_pending;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a sense takes priority over the pulse end or timeout
    always_comb begin
        next_state = state;
        sensed     = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (credit != '0) next_state = S_EJECT;
            end
            S_EJECT: begin
                if (coin_sensed) begin
                    next_state = S_IDLE;
                    sensed     = 1'b1;
                end else if (timer == TW'(PULSE_CYCLES - 1)) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (coin_sensed) begin
                    next_state = S_IDLE;
                    sensed     = 1'b1;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout    = 1'b1;
                    next_state = coin_type ? S_IDLE : S_FAULT;
                end
            end
            S_FAULT: begin
                if (clear_fault) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        coin_eject   = (state == S_EJECT);
        fault        = (state == S_FAULT);
        busy         = (state != S_IDLE) || (credit != '0);
        item_release = (item_cnt != '0);
    end

    assign paid       = sensed ? (coin_type ? 2'd2 : 2'd1) : 2'd0;
    assign credit_sum = {2'b00, credit} + {{(CW+1){1'b0}}, change_1}
                      + {{CW{1'b0}}, change_2, 1'b0} - {{CW{1'b0}}, paid};

    // Timer restarts on every state change and runs only while a coin is out
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (state != next_state) begin
            timer <= '0;
        end else if (state == S_EJECT || state == S_WAIT) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credit    <= '0;
            overflow  <= 1'b0;
            h2_empty  <= 1'b0;
            coin_type <= 1'b0;
        end else begin
            if (credit_sum > {2'b00, CMAX}) begin
                credit   <= CMAX;
                overflow <= 1'b1;
            end else begin
                credit <= credit_sum[CW-1:0];
            end
            if (state == S_WAIT && timeout && coin_type) begin
                h2_empty <= 1'b1;
            end else if (state == S_FAULT && clear_fault) begin
                h2_empty <= 1'b0;
            end
            if (state == S_IDLE && next_state == S_EJECT) begin
                coin_type <= (credit >= CW'(2)) && !h2_empty;
            end
        end
    end

    // Item pulses: one queued vend is chained directly onto the active pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            item_cnt     <= '0;
            item_pending <= 1'b0;
        end else if (item_cnt == '0) begin
            if (vend) item_cnt <= IW'(PULSE_CYCLES);
        end else if (item_cnt == IW'(1)) begin
            item_cnt     <= (item_pending || vend) ? IW'(PULSE_CYCLES) : '0;
            item_pending <= 1'b0;
        end else begin
            item_cnt <= item_cnt - 1'b1;
            if (vend) item_pending <= 1'b1;
        end
    end

endmodule

`default_nettype wire
